// File: rtl/rs_age_issue.sv
// Age-ordered reservation station: buffers dispatched ops, wakes operands from
// NUM_CDB broadcast channels, issues the oldest ready op into a valid/ready output register.
module rs_age_issue #(
    parameter int RS_DEPTH = 16,
    parameter int NUM_CDB  = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         dsp_valid,
    input  logic [OPENUM_W-1:0]          dsp_openum,
    input  logic [DATA_W-1:0]            dsp_v1,
    input  logic [DATA_W-1:0]            dsp_v2,
    input  logic [ROB_ID_W-1:0]          dsp_q1,
    input  logic [ROB_ID_W-1:0]          dsp_q2,
    input  logic [ADDR_W-1:0]            dsp_pc,
    input  logic [DATA_W-1:0]            dsp_imm,
    input  logic [ROB_ID_W-1:0]          dsp_rob_id,
    output logic                         full,
    output logic [$clog2(RS_DEPTH):0]    count,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_result,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [OPENUM_W-1:0]          issue_openum,
    output logic [DATA_W-1:0]            issue_v1,
    output logic [DATA_W-1:0]            issue_v2,
    output logic [ADDR_W-1:0]            issue_pc,
    output logic [DATA_W-1:0]            issue_imm,
    output logic [ROB_ID_W-1:0]          issue_rob_id
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [IDX_W-1:0]    rank_q   [RS_DEPTH];
    logic [IDX_W-1:0]    rank_d   [RS_DEPTH];
    logic [OPENUM_W-1:0] openum_q [RS_DEPTH];
    logic [OPENUM_W-1:0] openum_d [RS_DEPTH];
    logic [DATA_W-1:0]   v1_q     [RS_DEPTH];
    logic [DATA_W-1:0]   v1_d     [RS_DEPTH];
    logic [DATA_W-1:0]   v2_q     [RS_DEPTH];
    logic [DATA_W-1:0]   v2_d     [RS_DEPTH];
    logic [ROB_ID_W-1:0] q1_q     [RS_DEPTH];
    logic [ROB_ID_W-1:0] q1_d     [RS_DEPTH];
    logic [ROB_ID_W-1:0] q2_q     [RS_DEPTH];
    logic [ROB_ID_W-1:0] q2_d     [RS_DEPTH];
    logic [ADDR_W-1:0]   pc_q     [RS_DEPTH];
    logic [ADDR_W-1:0]   pc_d     [RS_DEPTH];
    logic [DATA_W-1:0]   imm_q    [RS_DEPTH];
    logic [DATA_W-1:0]   imm_d    [RS_DEPTH];
    logic [ROB_ID_W-1:0] rob_q    [RS_DEPTH];
    logic [ROB_ID_W-1:0] rob_d    [RS_DEPTH];

    logic [CNT_W-1:0]    count_q, count_d;
    logic                issue_valid_q, issue_valid_d;
    logic [OPENUM_W-1:0] issue_openum_q, issue_openum_d;
    logic [DATA_W-1:0]   issue_v1_q, issue_v1_d;
    logic [DATA_W-1:0]   issue_v2_q, issue_v2_d;
    logic [ADDR_W-1:0]   issue_pc_q, issue_pc_d;
    logic [DATA_W-1:0]   issue_imm_q, issue_imm_d;
    logic [ROB_ID_W-1:0] issue_rob_id_q, issue_rob_id_d;

    logic [RS_DEPTH-1:0] ready;
    logic                sel_found, free_found;
    logic [IDX_W-1:0]    sel_idx, sel_rank, free_idx, new_rank;
    logic                can_load, do_issue, do_insert;
    logic [ROB_ID_W-1:0] byp_q1, byp_q2;
    logic [DATA_W-1:0]   byp_v1, byp_v2;

    assign full         = (count_q == CNT_W'(RS_DEPTH));
    assign count        = count_q;
    assign issue_valid  = issue_valid_q;
    assign issue_openum = issue_openum_q;
    assign issue_v1     = issue_v1_q;
    assign issue_v2     = issue_v2_q;
    assign issue_pc     = issue_pc_q;
    assign issue_imm    = issue_imm_q;
    assign issue_rob_id = issue_rob_id_q;

    // Oldest-ready pick and lowest free slot, both on registered state
    always_comb begin
        ready      = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_rank   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            ready[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
            if (ready[i] && (!sel_found || rank_q[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rank  = rank_q[i];
            end
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        can_load  = !issue_valid_q || issue_ready;
        do_issue  = can_load && sel_found;
        do_insert = dsp_valid && !full;
        new_rank  = IDX_W'(count_q - CNT_W'(do_issue));
    end

    // Channels scanned high to low so the lowest matching channel ends up winning
    always_comb begin
        byp_q1 = dsp_q1;
        byp_v1 = dsp_v1;
        byp_q2 = dsp_q2;
        byp_v2 = dsp_v2;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[NUM_CDB-1-k]) begin
                if (dsp_q1 != '0 && dsp_q1 == cdb_rob_id[(NUM_CDB-1-k)*ROB_ID_W +: ROB_ID_W]) begin
                    byp_q1 = '0;
                    byp_v1 = cdb_result[(NUM_CDB-1-k)*DATA_W +: DATA_W];
                end
                if (dsp_q2 != '0 && dsp_q2 == cdb_rob_id[(NUM_CDB-1-k)*ROB_ID_W +: ROB_ID_W]) begin
                    byp_q2 = '0;
                    byp_v2 = cdb_result[(NUM_CDB-1-k)*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        busy_d         = busy_q;
        rank_d         = rank_q;
        openum_d       = openum_q;
        v1_d           = v1_q;
        v2_d           = v2_q;
        q1_d           = q1_q;
        q2_d           = q2_q;
        pc_d           = pc_q;
        imm_d          = imm_q;
        rob_d          = rob_q;
        count_d        = count_q;
        issue_valid_d  = issue_valid_q;
        issue_openum_d = issue_openum_q;
        issue_v1_d     = issue_v1_q;
        issue_v2_d     = issue_v2_q;
        issue_pc_d     = issue_pc_q;
        issue_imm_d    = issue_imm_q;
        issue_rob_id_d = issue_rob_id_q;
        if (rdy) begin
            if (flush) begin
                busy_d         = '0;
                count_d        = '0;
                issue_valid_d  = 1'b0;
                issue_openum_d = '0;
            end else begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    for (int unsigned k = 0; k < NUM_CDB; k++) begin
                        if (busy_q[i] && cdb_valid[NUM_CDB-1-k]) begin
                            if (q1_q[i] != '0 && q1_q[i] == cdb_rob_id[(NUM_CDB-1-k)*ROB_ID_W +: ROB_ID_W]) begin
                                q1_d[i] = '0;
                                v1_d[i] = cdb_result[(NUM_CDB-1-k)*DATA_W +: DATA_W];
                            end
                            if (q2_q[i] != '0 && q2_q[i] == cdb_rob_id[(NUM_CDB-1-k)*ROB_ID_W +: ROB_ID_W]) begin
                                q2_d[i] = '0;
                                v2_d[i] = cdb_result[(NUM_CDB-1-k)*DATA_W +: DATA_W];
                            end
                        end
                    end
                    if (do_issue && busy_q[i] && rank_q[i] > sel_rank) begin
                        rank_d[i] = rank_q[i] - 1'b1;
                    end
                end
                if (do_issue) begin
                    busy_d[sel_idx] = 1'b0;
                    issue_valid_d   = 1'b1;
                    issue_openum_d  = openum_q[sel_idx];
                    issue_v1_d      = v1_q[sel_idx];
                    issue_v2_d      = v2_q[sel_idx];
                    issue_pc_d      = pc_q[sel_idx];
                    issue_imm_d     = imm_q[sel_idx];
                    issue_rob_id_d  = rob_q[sel_idx];
                end else if (can_load) begin
                    issue_valid_d  = 1'b0;
                    issue_openum_d = '0;
                end
                if (do_insert) begin
                    busy_d[free_idx]   = 1'b1;
                    rank_d[free_idx]   = new_rank;
                    openum_d[free_idx] = dsp_openum;
                    v1_d[free_idx]     = byp_v1;
                    v2_d[free_idx]     = byp_v2;
                    q1_d[free_idx]     = byp_q1;
                    q2_d[free_idx]     = byp_q2;
                    pc_d[free_idx]     = dsp_pc;
                    imm_d[free_idx]    = dsp_imm;
                    rob_d[free_idx]    = dsp_rob_id;
                end
                count_d = count_q + CNT_W'(do_insert) - CNT_W'(do_issue);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q         <= '0;
            count_q        <= '0;
            issue_valid_q  <= 1'b0;
            issue_openum_q <= '0;
            issue_v1_q     <= '0;
            issue_v2_q     <= '0;
            issue_pc_q     <= '0;
            issue_imm_q    <= '0;
            issue_rob_id_q <= '0;
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                rank_q[i]   <= '0;
                openum_q[i] <= '0;
                v1_q[i]     <= '0;
                v2_q[i]     <= '0;
                q1_q[i]     <= '0;
                q2_q[i]     <= '0;
                pc_q[i]     <= '0;
                imm_q[i]    <= '0;
                rob_q[i]    <= '0;
            end
        end else begin
            busy_q         <= busy_d;
            count_q        <= count_d;
            issue_valid_q  <= issue_valid_d;
            issue_openum_q <= issue_openum_d;
            issue_v1_q     <= issue_v1_d;
            issue_v2_q     <= issue_v2_d;
            issue_pc_q     <= issue_pc_d;
            issue_imm_q    <= issue_imm_d;
            issue_rob_id_q <= issue_rob_id_d;
            rank_q         <= rank_d;
            openum_q       <= openum_d;
            v1_q           <= v1_d;
            v2_q           <= v2_d;
            q1_q           <= q1_d;
            q2_q           <= q2_d;
            pc_q           <= pc_d;
            imm_q          <= imm_d;
            rob_q          <= rob_d;
        end
    end

endmodule

// File: doc/rs_age_issue.md
# rs_age_issue

Parametrised reservation station for the ALU/branch execution path: it buffers dispatched micro-ops, wakes operands from any number of CDB channels, and issues the oldest ready entry through a registered valid/ready port to the execution unit. It sits between the dispatcher and the ALU. Depth, widths and CDB channel count are parameters. Compared with the fixed 16-entry, two-CDB station, it adds age-ordered selection, downstream backpressure, an occupancy count and multi-channel wakeup.

## Interface
- RS_DEPTH, 16, number of entries (power of two, ≥2)
- NUM_CDB, 2, number of CDB broadcast channels
- DATA_W, 32, operand/result width
- ADDR_W, 32, pc width
- ROB_ID_W, 4, ROB tag width; tag 0 means "operand ready"
- OPENUM_W, 6, opcode-enum width; value 0 is NOP
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  jump-commit flush, synchronous
- dsp_valid  in  1  insert request
- dsp_openum  in  OPENUM_W  opcode
- dsp_v1, dsp_v2  in  DATA_W  operand values
- dsp_q1, dsp_q2  in  ROB_ID_W  operand tags
- dsp_pc  in  ADDR_W  instruction pc
- dsp_imm  in  DATA_W  immediate
- dsp_rob_id  in  ROB_ID_W  destination ROB tag
- full  out  1  count == RS_DEPTH
- count  out  clog2(RS_DEPTH)+1  valid entries
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_ID_W  channel k at bits [k*ROB_ID_W +: ROB_ID_W]
- cdb_result  in  NUM_CDB*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- issue_valid  out  1  output register holds an op
- issue_ready  in  1  EX accepts this cycle
- issue_openum, issue_v1, issue_v2, issue_pc, issue_imm, issue_rob_id  out  as dsp_*  issued op

## Operation
- Each entry holds busy, rank, openum, v1, v2, q1, q2, pc, imm, and rob_id.
- Wakeup: each cycle, for every busy entry and every channel with cdb_valid, a q equal to cdb_rob_id (and ≠0) takes v = result and q = 0. If several channels carry the same tag, the lowest channel index wins.
- Dispatch bypass: dsp_q1/dsp_q2 are compared against the same-cycle CDB using the same rule before being written. The captured value and q = 0 are stored.
- Insert: when dsp_valid && !full, the lowest-index free slot is written. Its rank is set to count minus the number of entries issuing this cycle. When full, the insert is dropped and state is unchanged; the dispatcher must gate on full.
- Ready: an entry is ready when busy && q1 == 0 && q2 == 0, evaluated on registered state.
- Age selection: among ready entries, the one with the smallest rank is chosen. Ranks of valid entries are always unique, spanning 0..count-1.
- Issue: a transfer occurs when the output register can load (!issue_valid || issue_ready) and a ready entry exists.
  - The chosen entry is copied to the issue_* registers and freed.
  - All entries with a larger rank decrement their rank by 1.
  - issue_valid is set.
- Drain: if the output register can load and no entry is ready, issue_valid is cleared and issue_openum is set to 0.
- Stall: with issue_valid && !issue_ready, issue_* hold unchanged.
- count: updated as count + insert − issue.
- flush (with rdy high): clears all busy bits, count, and issue_valid; sets issue_openum to 0. It overrides insert, wakeup and issue in that cycle.
- rdy low: no state changes, so CDB broadcasts in that cycle are not captured. Outputs hold.

## Timing
- Reset (rst low, asynchronous): all busy = 0, count = 0, full = 0, issue_valid = 0. All issue_* outputs are 0.
- Latency, ready-on-dispatch: insert at edge N gives issue_valid high after edge N+1.
- Latency, wakeup: a CDB tag matched at edge N makes the entry eligible in cycle N+1. Issue_valid is high after edge N+1.
- Throughput: one issue per cycle while issue_ready stays high.
- Simultaneous insert and issue in one cycle: both take effect. count is unchanged; full is recomputed from the new count.
- Releasing reset mid-operation: behaviour restarts from the empty state. No partial entries survive.

## Test plan
- Reset and idle:
  - Drive rst low mid-stream. full, count and issue_valid must be 0 immediately (asynchronous).
  - After release with no dispatch, issue_valid must stay 0.
- Age order:
  - Insert A(rob 1), B(rob 2) and C(rob 3), all with q = 0, one per cycle, with issue_ready = 0.
  - Then raise issue_ready. The issue order must be rob 1, 2, 3 on consecutive cycles, and count must step 3 → 0.
- Out-of-order wakeup:
  - Insert X(q1 = 5), then Y (ready).
  - Y must issue first.
  - Then drive cdb channel 1 with rob 5 and result 0xDEAD_BEEF. X must issue one cycle later with issue_v1 = 0xDEADBEEF.
- Dispatch bypass: dispatch with dsp_q2 = 7 while cdb channel 0 carries rob 7 and result 0x1234. The entry must issue next cycle with v2 = 0x1234.
- Full and backpressure:
  - Fill RS_DEPTH entries with issue_ready = 0. full must be 1 and count must equal 16.
  - An extra insert must be dropped.
  - issue_* must hold stable while stalled.
  - Releasing issue_ready must drain exactly 16 ops.
- Flush and rdy:
  - Hold rdy low for 3 cycles during a CDB broadcast. State must be unchanged and the broadcast must not be captured.
  - Then assert flush together with dsp_valid. Next cycle count must be 0, issue_valid 0, and the new op not inserted.
